ts_extract: RTL and testbench
=============================

TS_EXTRACT -- requirements
Module: ts_extract

Interface
REQ-001 The block SHALL have one clock, CLK; reset SHALL be asynchronous and active-low, port RESET.
REQ-002 Parameter WORD_SIZE, default 8, SHALL set the byte/data width.
REQ-003 Parameter FRAME_LEN, default 10, SHALL set the bytes per frame, including the sync byte.
REQ-004 Parameter LOCK_CNT, default 2, SHALL set the consecutive correctly spaced syncs needed to lock.
REQ-005 Parameter MISS_CNT, default 3, SHALL set the consecutive missing syncs that drop lock.
REQ-006 Parameter FIFO_DEPTH, default 16, SHALL set the output buffer entries (power of two).
REQ-007 Port list SHALL be, clock and reset first:
- CLK  in  1  clock
- RESET  in  1  async active-low reset
- TS_IN  in  WORD_SIZE  stream byte, one per CLK
- SYNC  in  1  frame-start strobe
- DOUT_READY  in  1  consumer accepts DOUT
- DOUT  out  WORD_SIZE  extracted payload byte
- DOUT_VALID  out  1  DOUT holds data
- LOCK  out  1  frame alignment held
- SYNC_ERR  out  1  one-cycle sync anomaly pulse
- OVF  out  1  sticky overflow

Function
REQ-008 A sync event SHALL be SYNC=1 with TS_IN=8'hFF sampled on a CLK edge.
REQ-009 A position counter pos SHALL run 0..FRAME_LEN-1, wrap to 0, and be forced to 0 on any accepted sync.
REQ-010 HUNT: on a sync event, the FSM SHALL go to VERIFY with pos=0 and good=1; otherwise it stays in HUNT.
REQ-011 VERIFY: a sync at pos wrap SHALL increment good, and good==LOCK_CNT SHALL enter LOCK.
REQ-012 VERIFY: a sync at any other pos SHALL pulse SYNC_ERR and restart VERIFY with pos=0 and good=1.
REQ-013 VERIFY: no sync at pos wrap SHALL pulse SYNC_ERR and return to HUNT.
REQ-014 LOCK: the payload bytes at pos 1..FRAME_LEN-1 SHALL be pushed to the FIFO; sync bytes SHALL never be pushed.
REQ-015 LOCK: a sync at pos wrap SHALL clear miss.
REQ-016 LOCK: no sync at pos wrap SHALL pulse SYNC_ERR, increment miss, and treat the cycle as frame start (flywheel) with the byte not pushed.
REQ-017 LOCK: miss reaching MISS_CNT SHALL go to HUNT and drop LOCK the same edge.
REQ-018 LOCK: a sync event at a non-wrap pos SHALL pulse SYNC_ERR, not push that byte, and not realign.
REQ-019 LOCK SHALL be high exactly while the FSM is in LOCK.
REQ-020 Latency: a payload byte sampled at edge k SHALL appear on DOUT with DOUT_VALID after edge k+1 when the FIFO was empty.
REQ-021 The FIFO SHALL be first-word-fall-through, with DOUT_VALID = not empty.
REQ-022 The FIFO SHALL pop on DOUT_VALID and DOUT_READY.
REQ-023 Bytes SHALL leave in arrival order.
REQ-024 A push when full with no simultaneous pop SHALL drop the byte and set OVF until reset.
REQ-025 A push when full with a simultaneous pop SHALL be accepted.
REQ-026 A push and pop in the same cycle SHALL keep the count unchanged, including when empty with bypass disallowed: that byte appears next cycle.

Reset
REQ-027 Asserting RESET at any time, including mid-frame, SHALL immediately set the FSM to HUNT, pos/good/miss=0, FIFO empty, DOUT=0, DOUT_VALID=0, LOCK=0, SYNC_ERR=0, OVF=0.
REQ-028 After RESET deasserts, the first sync event SHALL be handled per REQ-010.

Configuration
REQ-029 Macro TS_EXTRACT_FLYWHEEL_EN defined SHALL enable the MISS_CNT flywheel of REQ-016/017.
REQ-030 Without TS_EXTRACT_FLYWHEEL_EN, the first missing sync at pos wrap in LOCK SHALL pulse SYNC_ERR and go to HUNT; MISS_CNT is then unused.

Structure
REQ-031 Shared package ts_pkg SHALL hold SYNC_BYTE=8'hFF, the default WORD_SIZE, and the FSM state encoding (HUNT, VERIFY, LOCK).
REQ-032 The output buffer SHALL be a sub-module ts_sync_fifo (WORD_SIZE, FIFO_DEPTH, full/empty, FWFT).

Verification
REQ-033 Frames FF,03,02,07,06,0F,0E,0C,06,0F then FF,EE,EE,00x7 -> LOCK rises after the second FF; DOUT yields EE,EE,00x7; nothing from frame 1.
REQ-034 Locked, one sync replaced by 00/SYNC=0 -> one SYNC_ERR pulse, LOCK stays, next 9 bytes output; three consecutive misses -> LOCK falls at the third wrap.
REQ-035 Locked, DOUT_READY=0 for 3 frames (27 payload bytes) -> first 16 bytes retained in order, OVF=1; raising DOUT_READY drains exactly 16 bytes.
REQ-036 In VERIFY, a sync at pos 5 -> SYNC_ERR pulse, realign to that sync, LOCK after the next correctly spaced sync.
REQ-037 RESET low mid-LOCK with 5 bytes buffered -> LOCK, DOUT_VALID, and OVF low before the next CLK edge; FIFO empty after release.
REQ-038 Build without TS_EXTRACT_FLYWHEEL_EN, one missing sync -> SYNC_ERR, LOCK=0, FSM in HUNT.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared definitions for the transport-stream frame extractor: sync byte value,
// default data width, framing FSM encoding and a counter-width helper.
package ts_pkg;

    localparam int         WORD_SIZE_DEF = 8;
    localparam logic [7:0] SYNC_BYTE     = 8'hFF;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } ts_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ts_sync_fifo.sv
// First-word-fall-through output buffer. FIFO_DEPTH must be a power of two so
// the read/write pointers wrap naturally. A push while full is accepted only
// when a pop happens on the same edge; otherwise the byte is dropped here and
// the caller decides what to report. DOUT reads as zero while empty.
module ts_sync_fifo
    import ts_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 full,
    output logic                 empty
);
    localparam int            AW        = cnt_w(FIFO_DEPTH);
    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, wr_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_q];

    // Pointer and occupancy update; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents need no reset since emptiness is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= wdata;
    end

endmodule

// File: rtl/ts_extract.sv
// Transport-stream frame aligner and payload extractor.
// HUNT -> VERIFY -> LOCK on correctly spaced sync bytes; payload bytes of locked
// frames are registered once and then written into a FWFT output buffer.
// Optional build macro: TS_EXTRACT_FLYWHEEL_EN enables tolerating up to
// MISS_CNT-1 consecutive missing syncs while locked; without it the first
// missing sync drops lock.
module ts_extract
    import ts_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int FRAME_LEN  = 10,
    parameter int LOCK_CNT   = 2,
    parameter int MISS_CNT   = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WORD_SIZE-1:0] TS_IN,
    input  logic                 SYNC,
    input  logic                 DOUT_READY,
    output logic [WORD_SIZE-1:0] DOUT,
    output logic                 DOUT_VALID,
    output logic                 LOCK,
    output logic                 SYNC_ERR,
    output logic                 OVF
);
    localparam int            PW        = cnt_w(FRAME_LEN);
    localparam int            GW        = cnt_w(LOCK_CNT + 1);
    localparam int            MW        = cnt_w(MISS_CNT + 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_DROP = MW'(MISS_CNT);
`ifdef TS_EXTRACT_FLYWHEEL_EN
    localparam bit            FLYWHEEL  = 1'b1;
`else
    localparam bit            FLYWHEEL  = 1'b0;
`endif

    ts_state_e            state_q, state_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic [GW-1:0]        good_q, good_d;
    logic [MW-1:0]        miss_q, miss_d;
    logic                 sync_err_q, sync_err_d;
    logic                 push_q, push_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 ovf_q, ovf_d;

    logic                 sync_ev;
    logic                 wrap;
    logic [PW-1:0]        pos_nxt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;

    // pos_q is the frame position of the previously sampled byte, so "wrap"
    // means the byte now on TS_IN is where the next sync is expected.
    assign sync_ev  = SYNC && (TS_IN == WORD_SIZE'(SYNC_BYTE));
    assign wrap     = (pos_q == POS_LAST);
    assign pos_nxt  = wrap ? '0 : pos_q + 1'b1;

    assign LOCK       = (state_q == ST_LOCK);
    assign SYNC_ERR   = sync_err_q;
    assign OVF        = ovf_q;
    assign DOUT_VALID = !fifo_empty;
    assign fifo_pop   = DOUT_READY && DOUT_VALID;

    // Framing FSM: next state, counters, anomaly pulse and payload push decision.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        good_d     = good_q;
        miss_d     = miss_q;
        sync_err_d = 1'b0;
        push_d     = 1'b0;
        wdata_d    = TS_IN;
        unique case (state_q)
            ST_HUNT: begin
                if (sync_ev) begin
                    state_d = ST_VERIFY;
                    pos_d   = '0;
                    good_d  = GW'(1);
                end
            end
            ST_VERIFY: begin
                pos_d = pos_nxt;
                if (wrap) begin
                    if (sync_ev) begin
                        good_d = good_q + 1'b1;
                        if (good_q + 1'b1 == GOOD_LOCK) begin
                            state_d = ST_LOCK;
                            miss_d  = '0;
                        end
                    end else begin
                        sync_err_d = 1'b1;
                        state_d    = ST_HUNT;
                        good_d     = '0;
                    end
                end else if (sync_ev) begin
                    // Misplaced sync: trust the newer one and start counting again.
                    sync_err_d = 1'b1;
                    pos_d      = '0;
                    good_d     = GW'(1);
                end
            end
            ST_LOCK: begin
                pos_d = pos_nxt;
                if (wrap) begin
                    if (sync_ev) begin
                        miss_d = '0;
                    end else begin
                        // Missing sync: keep frame timing (flywheel) unless too many in a row.
                        sync_err_d = 1'b1;
                        miss_d     = miss_q + 1'b1;
                        if (!FLYWHEEL || (miss_q + 1'b1 == MISS_DROP)) begin
                            state_d = ST_HUNT;
                            good_d  = '0;
                            miss_d  = '0;
                        end
                    end
                end else if (sync_ev) begin
                    // Stray sync inside a locked frame: flag and discard, no realign.
                    sync_err_d = 1'b1;
                end else begin
                    push_d = 1'b1;
                end
            end
            default: state_d = ST_HUNT;
        endcase
        ovf_d = ovf_q || (push_q && fifo_full && !fifo_pop);
    end

    // Control registers with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_HUNT;
            pos_q      <= '0;
            good_q     <= '0;
            miss_q     <= '0;
            sync_err_q <= 1'b0;
            push_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            sync_err_q <= sync_err_d;
            push_q     <= push_d;
            ovf_q      <= ovf_d;
        end
    end

    // Payload data stage; qualified by push_q so it needs no reset.
    always_ff @(posedge CLK) begin
        wdata_q <= wdata_d;
    end

    ts_sync_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (CLK),
        .rst_n(RESET),
        .push (push_q),
        .wdata(wdata_q),
        .pop  (fifo_pop),
        .rdata(DOUT),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule

// File: tb/tb_ts_extract.sv
// Bench for ts_extract: randomized and directed byte streams, a frame-level
// reference model and a scoreboard queue drained by an independent monitor.
module tb_ts_extract;

    localparam int WORD_SIZE  = 8;
    localparam int FRAME_LEN  = 10;
    localparam int LOCK_CNT   = 2;
    localparam int MISS_CNT   = 3;
    localparam int FIFO_DEPTH = 16;
`ifdef TS_EXTRACT_FLYWHEEL_EN
    localparam bit FLY = 1'b1;
`else
    localparam bit FLY = 1'b0;
`endif

    logic                 CLK = 1'b0;
    logic                 RESET = 1'b1;
    logic [WORD_SIZE-1:0] TS_IN = '0;
    logic                 SYNC = 1'b0;
    logic                 DOUT_READY = 1'b0;
    logic [WORD_SIZE-1:0] DOUT;
    logic                 DOUT_VALID;
    logic                 LOCK;
    logic                 SYNC_ERR;
    logic                 OVF;

    ts_extract #(
        .WORD_SIZE (WORD_SIZE),
        .FRAME_LEN (FRAME_LEN),
        .LOCK_CNT  (LOCK_CNT),
        .MISS_CNT  (MISS_CNT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .TS_IN     (TS_IN),
        .SYNC      (SYNC),
        .DOUT_READY(DOUT_READY),
        .DOUT      (DOUT),
        .DOUT_VALID(DOUT_VALID),
        .LOCK      (LOCK),
        .SYNC_ERR  (SYNC_ERR),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef enum int {M_HUNT, M_VERIFY, M_LOCK} mode_t;

    logic [7:0] sb[$];          // bytes expected on DOUT, in order
    mode_t      mode = M_HUNT;
    longint     idx = 0;        // running index of sampled bytes
    longint     anchor = 0;     // index of the byte that started current alignment
    int         hits = 0;
    int         misses = 0;
    int         mcnt = 0;       // expected buffer occupancy
    bit         pend = 0;       // a payload byte is on its way to the buffer
    logic [7:0] pend_b = '0;
    bit         exp_err = 0;
    bit         exp_lock = 0;
    bit         exp_ovf = 0;

    task automatic model_reset();
        mode = M_HUNT; hits = 0; misses = 0; mcnt = 0;
        pend = 0; exp_err = 0; exp_lock = 0; exp_ovf = 0;
        sb.delete();
    endtask

    // Frame rules: a sync is expected every FRAME_LEN bytes after the anchor.
    task automatic frame_rules(input bit s, input logic [7:0] b);
        bit ev;
        bit at_start;
        ev       = s && (b == 8'hFF);
        at_start = ((idx - anchor) % FRAME_LEN) == 0;
        exp_err  = 0;
        pend     = 0;
        pend_b   = b;
        case (mode)
            M_HUNT: if (ev) begin mode = M_VERIFY; anchor = idx; hits = 1; end
            M_VERIFY: begin
                if (at_start) begin
                    if (ev) begin
                        hits++;
                        if (hits == LOCK_CNT) begin mode = M_LOCK; misses = 0; end
                    end else begin
                        exp_err = 1; mode = M_HUNT;
                    end
                end else if (ev) begin
                    exp_err = 1; anchor = idx; hits = 1;
                end
            end
            default: begin
                if (at_start) begin
                    if (ev) misses = 0;
                    else begin
                        exp_err = 1; misses++;
                        if (!FLY || misses == MISS_CNT) mode = M_HUNT;
                    end
                end else if (ev) exp_err = 1;
                else pend = 1;
            end
        endcase
        exp_lock = (mode == M_LOCK);
    endtask

    // Everything that happens at one rising edge, from the bench's point of view.
    task automatic model_edge(input bit s, input logic [7:0] b, input bit rdy);
        bit pop;
        pop = rdy && (mcnt > 0);
        if (pend) begin
            if (mcnt < FIFO_DEPTH || pop) begin
                sb.push_back(pend_b);
                mcnt++;
            end else begin
                exp_ovf = 1;
            end
        end
        if (pop) mcnt--;
        frame_rules(s, b);
        idx++;
    endtask

    // ---------------- monitor ----------------
    logic [7:0] mon_exp;
    always @(negedge CLK) begin
        if (RESET) begin
            check("dout_valid", {31'b0, DOUT_VALID}, {31'b0, sb.size() != 0});
            if (DOUT_VALID && DOUT_READY) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dout_extra: got %0h required nothing at %0t", DOUT, $time);
                end else begin
                    mon_exp = sb.pop_front();
                    check("dout", {24'b0, DOUT}, {24'b0, mon_exp});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit s, input logic [7:0] b, input bit rdy);
        SYNC = s; TS_IN = b; DOUT_READY = rdy;
        @(posedge CLK);
        model_edge(s, b, rdy);
        #1;
        check("lock", {31'b0, LOCK}, {31'b0, exp_lock});
        check("sync_err", {31'b0, SYNC_ERR}, {31'b0, exp_err});
        check("ovf", {31'b0, OVF}, {31'b0, exp_ovf});
    endtask

    function automatic bit rnd_rdy(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    // One frame: sync (or a 00 non-sync when good_sync=0) plus random payload.
    task automatic send_frame(input bit good_sync, input int rdy_pct, input int stray_pct);
        logic [7:0] b;
        if (good_sync) step(1'b1, 8'hFF, rnd_rdy(rdy_pct));
        else           step(1'b0, 8'h00, rnd_rdy(rdy_pct));
        for (int i = 1; i < FRAME_LEN; i++) begin
            if ($urandom_range(99) < stray_pct) step(1'b1, 8'hFF, rnd_rdy(rdy_pct));
            else begin
                b = 8'($urandom_range(255));
                step(($urandom_range(9) == 0) && (b != 8'hFF), b, rnd_rdy(rdy_pct));
            end
        end
    endtask

    // Feed idle bytes until lock is lost and the buffer has drained.
    task automatic settle();
        for (int i = 0; i < 4 * FRAME_LEN + FIFO_DEPTH; i++) step(1'b0, 8'h00, 1'b1);
        check("drained", sb.size(), 0);
        check("hunt_after_idle", {31'b0, LOCK}, 32'd0);
    endtask

    task automatic async_reset_checked(input string tag);
        SYNC = 1'b0; TS_IN = '0;
        RESET = 1'b0;
        #1;
        check({tag, "_lock"}, {31'b0, LOCK}, 32'd0);
        check({tag, "_dout_valid"}, {31'b0, DOUT_VALID}, 32'd0);
        check({tag, "_ovf"}, {31'b0, OVF}, 32'd0);
        check({tag, "_sync_err"}, {31'b0, SYNC_ERR}, 32'd0);
        check({tag, "_dout"}, {24'b0, DOUT}, 32'd0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
    endtask

    logic [7:0] f1 [FRAME_LEN] = '{8'hFF, 8'h03, 8'h02, 8'h07, 8'h06, 8'h0F, 8'h0E, 8'h0C, 8'h06, 8'h0F};

    initial begin
        #2;
        async_reset_checked("reset0");

        // Two correctly spaced syncs lock; only the second frame's payload comes out.
        for (int i = 0; i < FRAME_LEN; i++) step(f1[i] == 8'hFF, f1[i], 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        check("lock_after_2nd_sync", {31'b0, LOCK}, 32'd1);
        step(1'b0, 8'hEE, 1'b1);
        step(1'b0, 8'hEE, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        send_frame(1'b1, 100, 0);
        settle();

        // Misplaced sync while verifying realigns to it.
        step(1'b1, 8'hFF, 1'b1);
        for (int i = 1; i < 5; i++) step(1'b0, 8'(i), 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        check("verify_realign_err", {31'b0, SYNC_ERR}, 32'd1);
        for (int i = 1; i < FRAME_LEN; i++) step(1'b0, 8'(8'h40 + i), 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        check("verify_realign_lock", {31'b0, LOCK}, 32'd1);
        for (int i = 1; i < FRAME_LEN; i++) step(1'b0, 8'(8'h50 + i), 1'b1);

        // One missing sync, then three in a row.
        send_frame(1'b0, 100, 0);
        send_frame(1'b1, 100, 0);
        send_frame(1'b0, 100, 0);
        send_frame(1'b0, 100, 0);
        send_frame(1'b0, 100, 0);
        settle();

        // Backpressure for three frames: buffer fills, overflow sticks, then drains.
        send_frame(1'b1, 100, 0);
        send_frame(1'b1, 100, 0);
        for (int f = 0; f < 3; f++) send_frame(1'b1, 0, 0);
        check("ovf_set", {31'b0, OVF}, 32'd1);
        check("full_valid", {31'b0, DOUT_VALID}, 32'd1);
        settle();

        // Reset in the middle of a locked frame with bytes buffered.
        send_frame(1'b1, 100, 0);
        send_frame(1'b1, 100, 0);
        step(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'(8'h70 + i), 1'b0);
        check("buffered_before_reset", {31'b0, DOUT_VALID}, 32'd1);
        async_reset_checked("reset_mid");
        for (int i = 0; i < 3; i++) step(1'b0, 8'h11, 1'b1);

        // Random traffic: occasional lost and stray syncs, random backpressure.
        for (int f = 0; f < 60; f++) send_frame($urandom_range(99) < 85, 80, 4);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
